// File: rtl/nand_flash_responder_if.sv
// NAND flash F_* bus between the flash controller (master) and the flash device model (slave).
interface nand_flash_responder_if;
  wire  [7:0] F_IO;
  logic       F_CLE;
  logic       F_ALE;
  logic       F_WEN;
  logic       F_REN;
  logic       F_RB;

  modport master (inout F_IO, output F_CLE, output F_ALE, output F_WEN, output F_REN, input F_RB);
  modport slave  (inout F_IO, input F_CLE, input F_ALE, input F_WEN, input F_REN, output F_RB);
endinterface

// File: rtl/nand_flash_responder.sv
// Cycle-based NAND flash device model: decodes CLE/ALE bytes strobed by F_WEN, serves page
// reads on F_IO under F_REN, and commits page programs with AND semantics while reporting busy.
module nand_flash_responder #(
  parameter int PAGE_W = 2,
  parameter int T_R    = 8,
  parameter int T_PROG = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nand_flash_responder_if.slave bus
);
  localparam int PAGE_BYTES = 512;
  localparam int MEM_DEPTH  = (2 ** PAGE_W) * PAGE_BYTES;
  localparam int CNT_W      = $clog2(PAGE_BYTES + T_PROG + T_R + 1);
  localparam logic [CNT_W-1:0] R_LAST   = CNT_W'(T_R - 1);
  localparam logic [CNT_W-1:0] P_LAST   = CNT_W'(PAGE_BYTES + T_PROG - 1);
  localparam logic [CNT_W-1:0] P_COMMIT = CNT_W'(PAGE_BYTES);

  typedef enum logic [2:0] {IDLE, ADDR, RBUSY, RDATA, PLOAD, PBUSY} state_t;

  state_t                  state, state_next;
  logic                    mode_pg;
  logic [1:0]              addr_cnt;
  logic [8:0]              col;
  logic [PAGE_W-1:0]       page;
  logic [CNT_W-1:0]        byte_cnt;
  logic                    wen_q, ren_q;
  logic [7:0]              dout;
  logic                    drive;
  logic                    rb, commit;

  // Erased flash reads FFh; the array keeps its contents across rst.
  logic [7:0]              mem [MEM_DEPTH] = '{default: 8'hFF};
  logic [7:0]              pbuf [PAGE_BYTES];
  logic [PAGE_BYTES-1:0]   pvalid;

  logic [7:0] io_in;
  logic       wr, rd_rise;
  logic       is_cmd, is_addr, is_data;
  logic       cmd_read, cmd_prog, cmd_conf, cmd_reset;
  logic       start_rd, start_pg;
  logic [8:0] ci;

  assign io_in     = bus.F_IO;
  assign wr        = ~wen_q & bus.F_WEN;
  assign rd_rise   = ~ren_q & bus.F_REN;
  assign is_cmd    = wr &  bus.F_CLE & ~bus.F_ALE;
  assign is_addr   = wr & ~bus.F_CLE &  bus.F_ALE;
  assign is_data   = wr & ~bus.F_CLE & ~bus.F_ALE;
  assign cmd_read  = is_cmd & (io_in == 8'h00 || io_in == 8'h01);
  assign cmd_prog  = is_cmd & (io_in == 8'h80);
  assign cmd_conf  = is_cmd & (io_in == 8'h10);
  assign cmd_reset = is_cmd & (io_in == 8'hFF);
  assign start_rd  = cmd_read & (state == IDLE || state == RDATA);
  assign start_pg  = cmd_prog & (state == IDLE || state == RDATA);
  assign ci        = byte_cnt[8:0];

  assign bus.F_RB  = rb;
  assign bus.F_IO  = drive ? dout : 8'hzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wen_q <= 1'b1;
      ren_q <= 1'b1;
    end else begin
      state <= state_next;
      wen_q <= bus.F_WEN;
      ren_q <= bus.F_REN;
    end
  end

  // FFh wins over everything, including busy; otherwise busy states only count down.
  always_comb begin
    state_next = state;
    rb         = 1'b1;
    commit     = 1'b0;
    if (state == RBUSY || state == PBUSY) rb = 1'b0;
    if (state == PBUSY && byte_cnt < P_COMMIT && !cmd_reset) commit = 1'b1;
    if (cmd_reset) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (cmd_read || cmd_prog) state_next = ADDR;
        ADDR:    if (is_addr && addr_cnt == 2'd2) state_next = mode_pg ? PLOAD : RBUSY;
        RBUSY:   if (byte_cnt == R_LAST) state_next = RDATA;
        RDATA:   if (cmd_read || cmd_prog) state_next = ADDR;
        PLOAD:   if (cmd_conf) state_next = PBUSY;
        PBUSY:   if (byte_cnt == P_LAST) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_pg  <= 1'b0;
      addr_cnt <= 2'd0;
      col      <= 9'd0;
      page     <= '0;
      byte_cnt <= '0;
      dout     <= 8'h00;
      drive    <= 1'b0;
    end else begin
      byte_cnt <= (!rb && state_next == state) ? byte_cnt + CNT_W'(1) : '0;
      dout     <= mem[{page, col}];
      drive    <= (state == RDATA) && !bus.F_REN;
      if (start_rd || start_pg) begin
        mode_pg  <= start_pg;
        addr_cnt <= 2'd0;
        col      <= {start_rd & io_in[0], 8'h00};
      end else if (state == ADDR && is_addr) begin
        addr_cnt <= addr_cnt + 2'd1;
        if (addr_cnt == 2'd0) col[7:0] <= io_in;
        if (addr_cnt == 2'd1) page <= io_in[PAGE_W-1:0];
      end else if (state == PLOAD && is_data) begin
        col <= col + 9'd1;
      end else if (state == RDATA && rd_rise && !wr) begin
        col <= col + 9'd1;
      end
    end
  end

  // Page buffer bytes never loaded since 80h count as FFh, so they leave the array untouched.
  always_ff @(posedge clk) begin
    if (start_pg) begin
      pvalid <= '0;
    end else if (state == PLOAD && is_data) begin
      pbuf[col]   <= io_in;
      pvalid[col] <= 1'b1;
    end
    if (commit) mem[{page, ci}] <= mem[{page, ci}] & (pvalid[ci] ? pbuf[ci] : 8'hFF);
  end
endmodule

// File: tb/tb_nand_flash_responder.sv
// Table-driven bench for nand_flash_responder: bus operations paired with expected F_RB,
// busy lengths and read bytes, followed by hand-written abort, reset and overlap sequences.
module tb_nand_flash_responder;
  localparam int T_R       = 8;
  localparam int T_PROG    = 16;
  localparam int PROG_BUSY = 512 + T_PROG;

  typedef enum logic [1:0] {K_WR, K_RD, K_REL, K_WAIT} kind_t;
  typedef struct {
    kind_t      kind;
    logic       cle;
    logic       ale;
    logic [7:0] data;
    int         expect_val;
    string      name;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_io = 8'h00;
  int         compared   = 0;
  int         mismatched = 0;
  vec_t       vecs[$];

  nand_flash_responder_if bus();
  assign bus.F_IO = tb_oe ? tb_io : 8'hzz;

  nand_flash_responder #(.PAGE_W(2), .T_R(T_R), .T_PROG(T_PROG)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(int i);
    logic [8:0] c;
    c = 9'(i);
    return c[7:0] ^ {c[8], 7'b0};
  endfunction

  function automatic vec_t mk(kind_t k, logic c, logic a, logic [7:0] d, int e, string n);
    vec_t v;
    v.kind = k; v.cle = c; v.ale = a; v.data = d; v.expect_val = e; v.name = n;
    return v;
  endfunction

  function automatic void add(kind_t k, logic c, logic a, logic [7:0] d, int e, string n);
    vecs.push_back(mk(k, c, a, d, e, n));
  endfunction

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Every operation starts and ends 1 time unit after a rising edge.
  task automatic apply_stimulus(input vec_t v);
    int n;
    case (v.kind)
      K_WR: begin
        bus.F_CLE = v.cle; bus.F_ALE = v.ale; tb_io = v.data; tb_oe = 1'b1;
        bus.F_WEN = 1'b0;
        @(posedge clk); #1;
        bus.F_WEN = 1'b1;
        @(posedge clk); #1;
        check_output(v.name, 32'(bus.F_RB), 32'(v.expect_val));
        bus.F_CLE = 1'b0; bus.F_ALE = 1'b0; tb_oe = 1'b0;
      end
      K_RD, K_REL: begin
        tb_io = 8'h00; tb_oe = (v.kind == K_REL);
        bus.F_REN = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_output(v.name, 32'(bus.F_IO), 32'(v.expect_val));
        bus.F_REN = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        tb_oe = 1'b0;
      end
      K_WAIT: begin
        n = 0;
        while (bus.F_RB !== 1'b1 && n < 4000) begin
          n++;
          @(posedge clk); #1;
        end
        check_output(v.name, 32'(n), 32'(v.expect_val));
      end
      default: ;
    endcase
  endtask

  task automatic op(kind_t k, logic c, logic a, logic [7:0] d, int e, string n);
    apply_stimulus(mk(k, c, a, d, e, n));
  endtask

  initial begin
    #1000000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    bus.F_CLE = 1'b0; bus.F_ALE = 1'b0; bus.F_WEN = 1'b1; bus.F_REN = 1'b1;

    // Idle bus release and bytes that must not change state.
    add(K_REL, 0, 0, 8'h00, 8'h00, "idle_release");
    add(K_WR,  1, 0, 8'h10, 1, "cmd10_in_idle");
    add(K_WR,  0, 1, 8'h55, 1, "addr_in_idle");
    add(K_WR,  1, 1, 8'h00, 1, "cle_ale_byte");
    add(K_WR,  0, 1, 8'h00, 1, "ign_addr0");
    add(K_WR,  0, 1, 8'h00, 1, "ign_addr1");
    add(K_WR,  0, 1, 8'h00, 1, "ign_addr2");
    add(K_REL, 0, 0, 8'h00, 8'h00, "idle_release2");
    // Program page 2, bytes 0..2.
    add(K_WR, 1, 0, 8'h80, 1, "p2_cmd80");
    add(K_WR, 0, 1, 8'h00, 1, "p2_a0");
    add(K_WR, 0, 1, 8'h02, 1, "p2_a1");
    add(K_WR, 0, 1, 8'h00, 1, "p2_a2");
    add(K_WR, 0, 0, 8'hA5, 1, "p2_d0");
    add(K_WR, 0, 0, 8'h5A, 1, "p2_d1");
    add(K_WR, 0, 0, 8'h3C, 1, "p2_d2");
    add(K_WR, 1, 0, 8'h10, 0, "p2_cmd10");
    add(K_WAIT, 0, 0, 8'h00, PROG_BUSY, "p2_prog_busy");
    // Read page 2 from column 0, then from column 272.
    add(K_WR, 1, 0, 8'h00, 1, "r2_cmd00");
    add(K_WR, 0, 1, 8'h00, 1, "r2_a0");
    add(K_WR, 0, 1, 8'h02, 1, "r2_a1");
    add(K_WR, 0, 1, 8'h00, 0, "r2_a2");
    add(K_WAIT, 0, 0, 8'h00, T_R, "r2_tr");
    add(K_RD, 0, 0, 8'h00, 8'hA5, "r2_b0");
    add(K_RD, 0, 0, 8'h00, 8'h5A, "r2_b1");
    add(K_RD, 0, 0, 8'h00, 8'h3C, "r2_b2");
    add(K_RD, 0, 0, 8'h00, 8'hFF, "r2_b3");
    add(K_WR, 1, 0, 8'h01, 1, "r2h_cmd01");
    add(K_WR, 0, 1, 8'h10, 1, "r2h_a0");
    add(K_WR, 0, 1, 8'h02, 1, "r2h_a1");
    add(K_WR, 0, 1, 8'h00, 0, "r2h_a2");
    add(K_WAIT, 0, 0, 8'h00, T_R, "r2h_tr");
    for (int i = 0; i < 4; i++) add(K_RD, 0, 0, 8'h00, 8'hFF, "r2h_erased");
    // Fill page 3 with a column-dependent pattern.
    add(K_WR, 1, 0, 8'h80, 1, "p3_cmd80");
    add(K_WR, 0, 1, 8'h00, 1, "p3_a0");
    add(K_WR, 0, 1, 8'h03, 1, "p3_a1");
    add(K_WR, 0, 1, 8'h00, 1, "p3_a2");
    for (int i = 0; i < 512; i++) add(K_WR, 0, 0, pat(i), 1, "p3_data");
    add(K_WR, 1, 0, 8'h10, 0, "p3_cmd10");
    add(K_WAIT, 0, 0, 8'h00, PROG_BUSY, "p3_prog_busy");
    add(K_WR, 1, 0, 8'h01, 1, "r3_cmd01");
    add(K_WR, 0, 1, 8'h10, 1, "r3_a0");
    add(K_WR, 0, 1, 8'h03, 1, "r3_a1");
    add(K_WR, 0, 1, 8'h00, 0, "r3_a2");
    add(K_WAIT, 0, 0, 8'h00, T_R, "r3_tr");
    for (int i = 272; i < 276; i++) add(K_RD, 0, 0, 8'h00, pat(i), "r3_hi_half");
    add(K_WR, 1, 0, 8'h01, 1, "wr_cmd01");
    add(K_WR, 0, 1, 8'hFF, 1, "wr_a0");
    add(K_WR, 0, 1, 8'h03, 1, "wr_a1");
    add(K_WR, 0, 1, 8'h00, 0, "wr_a2");
    add(K_WAIT, 0, 0, 8'h00, T_R, "wr_tr");
    add(K_RD, 0, 0, 8'h00, pat(511), "wrap_b511");
    add(K_RD, 0, 0, 8'h00, pat(0), "wrap_b0");
    add(K_WR, 1, 0, 8'h00, 1, "lo_cmd00");
    add(K_WR, 0, 1, 8'h10, 1, "lo_a0");
    add(K_WR, 0, 1, 8'h03, 1, "lo_a1");
    add(K_WR, 0, 1, 8'h00, 0, "lo_a2");
    add(K_WAIT, 0, 0, 8'h00, T_R, "lo_tr");
    add(K_RD, 0, 0, 8'h00, pat(16), "lo_b16");
    // Program 0Fh then F0h into page 1 byte 5; only cleared bits survive.
    for (int k = 0; k < 2; k++) begin
      add(K_WR, 1, 0, 8'h80, 1, "and_cmd80");
      add(K_WR, 0, 1, 8'h05, 1, "and_a0");
      add(K_WR, 0, 1, 8'h01, 1, "and_a1");
      add(K_WR, 0, 1, 8'h00, 1, "and_a2");
      add(K_WR, 0, 0, (k == 0) ? 8'h0F : 8'hF0, 1, "and_data");
      add(K_WR, 1, 0, 8'h10, 0, "and_cmd10");
      add(K_WAIT, 0, 0, 8'h00, PROG_BUSY, "and_prog_busy");
    end
    add(K_WR, 1, 0, 8'h00, 1, "and_rcmd");
    add(K_WR, 0, 1, 8'h05, 1, "and_ra0");
    add(K_WR, 0, 1, 8'h01, 1, "and_ra1");
    add(K_WR, 0, 1, 8'h00, 0, "and_ra2");
    add(K_WAIT, 0, 0, 8'h00, T_R, "and_tr");
    add(K_RD, 0, 0, 8'h00, 8'h00, "and_result");
    add(K_RD, 0, 0, 8'h00, 8'hFF, "and_neighbour");

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_rb", 32'(bus.F_RB), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Write strobe and read rise on the same edge: the read advance is dropped.
    op(K_WR, 1, 0, 8'h00, 1, "sim_cmd00");
    op(K_WR, 0, 1, 8'h20, 1, "sim_a0");
    op(K_WR, 0, 1, 8'h03, 1, "sim_a1");
    op(K_WR, 0, 1, 8'h00, 0, "sim_a2");
    op(K_WAIT, 0, 0, 8'h00, T_R, "sim_tr");
    op(K_RD, 0, 0, 8'h00, pat(32), "sim_b32");
    bus.F_REN = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_output("sim_pre", 32'(bus.F_IO), 32'(pat(33)));
    bus.F_WEN = 1'b0;
    @(posedge clk); #1;
    bus.F_WEN = 1'b1; bus.F_REN = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    op(K_RD, 0, 0, 8'h00, pat(33), "sim_rd_ignored");
    op(K_RD, 0, 0, 8'h00, pat(34), "sim_next");

    // FFh during program commit: bytes before commit index 100 land, the rest stay erased.
    op(K_WR, 1, 0, 8'h80, 1, "ab_cmd80");
    op(K_WR, 0, 1, 8'h62, 1, "ab_a0");
    op(K_WR, 0, 1, 8'h00, 1, "ab_a1");
    op(K_WR, 0, 1, 8'h00, 1, "ab_a2");
    for (int i = 0; i < 4; i++) op(K_WR, 0, 0, 8'h00, 1, "ab_data");
    op(K_WR, 1, 0, 8'h10, 0, "ab_cmd10");
    repeat (99) @(posedge clk);
    #1;
    check_output("ab_busy_before", 32'(bus.F_RB), 32'd0);
    op(K_WR, 1, 0, 8'hFF, 1, "ab_ffh_ready");
    op(K_WR, 1, 0, 8'h00, 1, "ab_rcmd");
    op(K_WR, 0, 1, 8'h62, 1, "ab_ra0");
    op(K_WR, 0, 1, 8'h00, 1, "ab_ra1");
    op(K_WR, 0, 1, 8'h00, 0, "ab_ra2");
    op(K_WAIT, 0, 0, 8'h00, T_R, "ab_tr");
    op(K_RD, 0, 0, 8'h00, 8'h00, "ab_b98");
    op(K_RD, 0, 0, 8'h00, 8'h00, "ab_b99");
    op(K_RD, 0, 0, 8'h00, 8'hFF, "ab_b100");
    op(K_RD, 0, 0, 8'h00, 8'hFF, "ab_b101");

    // Asynchronous reset during a read busy period; array contents survive.
    op(K_WR, 1, 0, 8'h00, 1, "rr_cmd00");
    op(K_WR, 0, 1, 8'h00, 1, "rr_a0");
    op(K_WR, 0, 1, 8'h02, 1, "rr_a1");
    op(K_WR, 0, 1, 8'h00, 0, "rr_a2");
    repeat (2) @(posedge clk);
    #1;
    check_output("rr_busy", 32'(bus.F_RB), 32'd0);
    rst = 1'b0;
    #1;
    check_output("rr_async_rb", 32'(bus.F_RB), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    op(K_REL, 0, 0, 8'h00, 8'h00, "rr_release");
    op(K_WR, 1, 0, 8'h00, 1, "rr2_cmd00");
    op(K_WR, 0, 1, 8'h00, 1, "rr2_a0");
    op(K_WR, 0, 1, 8'h02, 1, "rr2_a1");
    op(K_WR, 0, 1, 8'h00, 0, "rr2_a2");
    op(K_WAIT, 0, 0, 8'h00, T_R, "rr2_tr");
    op(K_RD, 0, 0, 8'h00, 8'hA5, "rr2_persist");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
